roll_animator: RTL and testbench



---
 rtl/roll_animator.sv | 188 ++++++++++++++++++
 tb/tb_roll_animator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roll_animator.sv
// roll_animator: two-player dice-roll engine.
// Each player owns an IDLE -> ROLL -> SETTLE FSM that turns a start pulse into a
// decelerating sequence of face updates and then settles on a final face 1..6.
// A single free-running 16-bit Galois LFSR supplies the randomness for both dice.
//
// Ports:
//   clk              system clock
//   rst              asynchronous, active-high reset
//   tick             1 kHz one-clk enable from the prescaler
//   start1/start2    debounced one-clk start pulses
//   dice1/dice2      current face of each die (1..6)
//   rolling1/2       high while that die is animating
//   done1/2          one-clk pulse when that die settles
//
// Build option: define ROLL_LOCK_EN to let only one die animate at a time
// (player 1 wins a same-clk tie from all-idle).
module roll_animator #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned FAST_TICKS = 20,
    parameter int unsigned STEP_TICKS = 10,
    parameter int unsigned SLOW_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start1,
    input  logic       start2,
    output logic [3:0] dice1,
    output logic [3:0] dice2,
    output logic       rolling1,
    output logic       rolling2,
    output logic       done1,
    output logic       done2
);

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FACE_W = 4;
    localparam int unsigned NPLAY  = 2;

    localparam logic [CNT_W-1:0]  FAST_L = CNT_W'(FAST_TICKS);
    localparam logic [CNT_W-1:0]  STEP_L = CNT_W'(STEP_TICKS);
    localparam logic [CNT_W-1:0]  SLOW_L = CNT_W'(SLOW_TICKS);
    // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    state_e            state_q    [NPLAY];
    state_e            state_d    [NPLAY];
    logic [CNT_W-1:0]  interval_q [NPLAY];
    logic [CNT_W-1:0]  interval_d [NPLAY];
    logic [CNT_W-1:0]  cnt_q      [NPLAY];
    logic [CNT_W-1:0]  cnt_d      [NPLAY];
    logic [FACE_W-1:0] face_q     [NPLAY];
    logic [FACE_W-1:0] face_d     [NPLAY];
    logic              rolling_q  [NPLAY];
    logic              rolling_d  [NPLAY];
    logic              done_q     [NPLAY];
    logic              done_d     [NPLAY];

    logic [2:0]        face_lo    [NPLAY];
    logic [2:0]        face_hi    [NPLAY];
    logic              start_ok   [NPLAY];

    // Candidate face: low field if it is 1..6, else high field, else previous face + 1 (6 wraps to 1)
    function automatic logic [FACE_W-1:0] next_face(
        input logic [2:0]        lo,
        input logic [2:0]        hi,
        input logic [FACE_W-1:0] prev
    );
        logic [FACE_W-1:0] f;
        if (lo >= 3'd1 && lo <= 3'd6) begin
            f = FACE_W'(lo);
        end else if (hi >= 3'd1 && hi <= 3'd6) begin
            f = FACE_W'(hi);
        end else if (prev == FACE_W'(6)) begin
            f = FACE_W'(1);
        end else begin
            f = FACE_W'(prev + FACE_W'(1));
        end
        return f;
    endfunction

    // Per-die LFSR field selection
    always_comb begin
        face_lo[0] = lfsr_q[2:0];
        face_hi[0] = lfsr_q[5:3];
        face_lo[1] = lfsr_q[10:8];
        face_hi[1] = lfsr_q[13:11];
    end

    // Start qualification (optionally mutually exclusive between players)
    always_comb begin
`ifdef ROLL_LOCK_EN
        start_ok[0] = start1 && (state_q[0] == IDLE) && (state_q[1] == IDLE);
        start_ok[1] = start2 && (state_q[0] == IDLE) && (state_q[1] == IDLE) && !start1;
`else
        start_ok[0] = start1 && (state_q[0] == IDLE);
        start_ok[1] = start2 && (state_q[1] == IDLE);
`endif
    end

    // Next-state and output logic for the LFSR and both player FSMs
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

        for (int p = 0; p < NPLAY; p++) begin
            state_d[p]    = state_q[p];
            interval_d[p] = interval_q[p];
            cnt_d[p]      = cnt_q[p];
            face_d[p]     = face_q[p];

            case (state_q[p])
                IDLE: begin
                    if (start_ok[p]) begin
                        state_d[p]    = ROLL;
                        interval_d[p] = FAST_L;
                        cnt_d[p]      = '0;
                    end
                end
                ROLL: begin
                    if (tick) begin
                        if (cnt_q[p] == CNT_W'(interval_q[p] - CNT_W'(1))) begin
                            face_d[p] = next_face(face_lo[p], face_hi[p], face_q[p]);
                            cnt_d[p]  = '0;
                            if (interval_q[p] == SLOW_L) begin
                                state_d[p] = SETTLE;
                            end else begin
                                interval_d[p] = CNT_W'(interval_q[p] + STEP_L);
                            end
                        end else begin
                            cnt_d[p] = CNT_W'(cnt_q[p] + CNT_W'(1));
                        end
                    end
                end
                SETTLE: begin
                    state_d[p] = IDLE;
                end
                default: begin
                    state_d[p] = IDLE;
                end
            endcase

            // Flags are registered from the next state so they align with it
            rolling_d[p] = (state_d[p] == ROLL);
            done_d[p]    = (state_d[p] == SETTLE);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            for (int p = 0; p < NPLAY; p++) begin
                state_q[p]    <= IDLE;
                interval_q[p] <= FAST_L;
                cnt_q[p]      <= '0;
                face_q[p]     <= FACE_W'(1);
                rolling_q[p]  <= 1'b0;
                done_q[p]     <= 1'b0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            for (int p = 0; p < NPLAY; p++) begin
                state_q[p]    <= state_d[p];
                interval_q[p] <= interval_d[p];
                cnt_q[p]      <= cnt_d[p];
                face_q[p]     <= face_d[p];
                rolling_q[p]  <= rolling_d[p];
                done_q[p]     <= done_d[p];
            end
        end
    end

    assign dice1    = face_q[0];
    assign dice2    = face_q[1];
    assign rolling1 = rolling_q[0];
    assign rolling2 = rolling_q[1];
    assign done1    = done_q[0];
    assign done2    = done_q[1];

endmodule

// File: tb/tb_roll_animator.sv
// Testbench for roll_animator: scenario tasks plus a reference model whose
// settled faces are queued and popped when the DUT pulses done.
module tb_roll_animator;

    localparam int FAST = 20;
    localparam int STEP = 10;
    localparam int SLOW = 200;
    localparam int NUPD = (SLOW - FAST) / STEP + 1;
    localparam int ROLL_TICKS = 2090;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [3:0] dice1, dice2;
    logic       rolling1, rolling2, done1, done2;

    int tests_run = 0;
    int tests_failed = 0;
    int golden_pops = 0;

    roll_animator dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start1   (start1),
        .start2   (start2),
        .dice1    (dice1),
        .dice2    (dice2),
        .rolling1 (rolling1),
        .rolling2 (rolling2),
        .done1    (done1),
        .done2    (done2)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [15:0] m_lfsr;
    logic [3:0]  e_dice [2];
    logic        e_roll [2];
    logic        e_done [2];
    logic        m_act  [2];
    logic        m_set  [2];
    int          m_ticks[2];
    int          m_next [2];
    int          m_k    [2];
    int          q0[$];
    int          q1[$];
    logic        m_idle0, m_idle1, m_ok0, m_ok1;

    function automatic logic [3:0] face_fn(input logic [2:0] lo, input logic [2:0] hi,
                                           input logic [3:0] prev);
        if (lo != 3'd0 && lo != 3'd7) return {1'b0, lo};
        if (hi != 3'd0 && hi != 3'd7) return {1'b0, hi};
        return (prev == 4'd6) ? 4'd1 : 4'(prev + 4'd1);
    endfunction

    assign m_idle0 = !m_act[0] && !m_set[0];
    assign m_idle1 = !m_act[1] && !m_set[1];
`ifdef ROLL_LOCK_EN
    assign m_ok0 = start1 && m_idle0 && m_idle1;
    assign m_ok1 = start2 && m_idle0 && m_idle1 && !start1;
`else
    assign m_ok0 = start1 && m_idle0;
    assign m_ok1 = start2 && m_idle1;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            for (int p = 0; p < 2; p++) begin
                e_dice[p]  <= 4'd1;
                e_roll[p]  <= 1'b0;
                e_done[p]  <= 1'b0;
                m_act[p]   <= 1'b0;
                m_set[p]   <= 1'b0;
                m_ticks[p] <= 0;
                m_next[p]  <= FAST;
                m_k[p]     <= 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            for (int p = 0; p < 2; p++) begin
                e_done[p] <= 1'b0;
                if (m_set[p]) begin
                    m_set[p] <= 1'b0;
                end else if (!m_act[p]) begin
                    if ((p == 0) ? m_ok0 : m_ok1) begin
                        m_act[p]   <= 1'b1;
                        m_ticks[p] <= 0;
                        m_k[p]     <= 0;
                        m_next[p]  <= FAST;
                        e_roll[p]  <= 1'b1;
                    end
                end else if (tick) begin
                    m_ticks[p] <= m_ticks[p] + 1;
                    if (m_ticks[p] + 1 == m_next[p]) begin
                        e_dice[p] <= (p == 0) ? face_fn(m_lfsr[2:0], m_lfsr[5:3], e_dice[0])
                                              : face_fn(m_lfsr[10:8], m_lfsr[13:11], e_dice[1]);
                        m_k[p]    <= m_k[p] + 1;
                        m_next[p] <= m_next[p] + FAST + (m_k[p] + 1) * STEP;
                        if (m_k[p] + 1 == NUPD) begin
                            m_act[p]  <= 1'b0;
                            m_set[p]  <= 1'b1;
                            e_roll[p] <= 1'b0;
                            e_done[p] <= 1'b1;
                            if (p == 0) q0.push_back(int'(face_fn(m_lfsr[2:0], m_lfsr[5:3], e_dice[0])));
                            else        q1.push_back(int'(face_fn(m_lfsr[10:8], m_lfsr[13:11], e_dice[1])));
                        end
                    end
                end
            end
        end
    end

    // Continuous output monitor and scoreboard consumer
    int sb_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                tests_run += 6;
                if (dice1 !== e_dice[0]) begin tests_failed++; $display("FAIL mon_dice1: got %0d expected %0d", dice1, e_dice[0]); end
                if (dice2 !== e_dice[1]) begin tests_failed++; $display("FAIL mon_dice2: got %0d expected %0d", dice2, e_dice[1]); end
                if (rolling1 !== e_roll[0]) begin tests_failed++; $display("FAIL mon_rolling1: got %0b expected %0b", rolling1, e_roll[0]); end
                if (rolling2 !== e_roll[1]) begin tests_failed++; $display("FAIL mon_rolling2: got %0b expected %0b", rolling2, e_roll[1]); end
                if (done1 !== e_done[0]) begin tests_failed++; $display("FAIL mon_done1: got %0b expected %0b", done1, e_done[0]); end
                if (done2 !== e_done[1]) begin tests_failed++; $display("FAIL mon_done2: got %0b expected %0b", done2, e_done[1]); end
                if (done1 === 1'b1) begin
                    tests_run++;
                    if (q0.size() == 0) begin
                        tests_failed++; $display("FAIL sb_settle1: got done1 with dice %0d expected no settle", dice1);
                    end else begin
                        sb_exp = q0.pop_front();
                        golden_pops++;
                        if (dice1 !== 4'(sb_exp)) begin tests_failed++; $display("FAIL sb_settle1: got %0d expected %0d", dice1, sb_exp); end
                    end
                end
                if (done2 === 1'b1) begin
                    tests_run++;
                    if (q1.size() == 0) begin
                        tests_failed++; $display("FAIL sb_settle2: got done2 with dice %0d expected no settle", dice2);
                    end else begin
                        sb_exp = q1.pop_front();
                        golden_pops++;
                        if (dice2 !== 4'(sb_exp)) begin tests_failed++; $display("FAIL sb_settle2: got %0d expected %0d", dice2, sb_exp); end
                    end
                end
            end
        end
    end

    // Drive inputs for one edge, then return #1 after it with inputs cleared
    task automatic step(input logic t, input logic s1, input logic s2);
        tick = t; start1 = s1; start2 = s2;
        @(posedge clk);
        #1;
        tick = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic test_reset();
        int dn = 0;
        int rl = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run += 4;
        if (dice1 !== 4'd1) begin tests_failed++; $display("FAIL reset_dice1: got %0d expected 1", dice1); end
        if (dice2 !== 4'd1) begin tests_failed++; $display("FAIL reset_dice2: got %0d expected 1", dice2); end
        if ({rolling1, rolling2} !== 2'b00) begin tests_failed++; $display("FAIL reset_rolling: got %0b expected 0", {rolling1, rolling2}); end
        if ({done1, done2} !== 2'b00) begin tests_failed++; $display("FAIL reset_done: got %0b expected 0", {done1, done2}); end
        rst = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done1 || done2) dn++;
            if (rolling1 || rolling2) rl++;
        end
        tests_run += 3;
        if (dn != 0) begin tests_failed++; $display("FAIL idle_done: got %0d pulses expected 0", dn); end
        if (rl != 0) begin tests_failed++; $display("FAIL idle_rolling: got %0d cycles expected 0", rl); end
        if ({dice1, dice2} !== 8'h11) begin tests_failed++; $display("FAIL idle_dice: got %0h expected 11", {dice1, dice2}); end
    endtask

    task automatic test_single_roll();
        int rt = 0, dn = 0, bad = 0, bad2 = 0;
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (rolling1 !== 1'b1) begin tests_failed++; $display("FAIL single_rolling_start: got %0b expected 1", rolling1); end
        for (int i = 0; i < 12000 && dn == 0; i++) begin
            logic t;
            t = ((i % 4) == 3);
            if (t && rolling1) rt++;
            step(t, 1'b0, 1'b0);
            if (done1) dn++;
            if (rolling1 && (dice1 < 4'd1 || dice1 > 4'd6)) bad++;
            if (dice2 !== 4'd1) bad2++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done1) dn++;
        end
        tests_run += 5;
        if (rt != ROLL_TICKS) begin tests_failed++; $display("FAIL single_ticks: got %0d expected %0d", rt, ROLL_TICKS); end
        if (dn != 1) begin tests_failed++; $display("FAIL single_done: got %0d pulses expected 1", dn); end
        if (bad != 0) begin tests_failed++; $display("FAIL single_range: got %0d bad faces expected 0", bad); end
        if (bad2 != 0) begin tests_failed++; $display("FAIL single_dice2: got %0d changes expected 0", bad2); end
        if (rolling1 !== 1'b0) begin tests_failed++; $display("FAIL single_rolling_end: got %0b expected 0", rolling1); end
    endtask

    task automatic test_retrigger();
        int rt = 0, dn = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000 && dn == 0; i++) begin
            if (rolling1) rt++;
            step(1'b1, (rt == 1000), 1'b0);
            if (done1) dn++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done1) dn++;
        end
        tests_run += 2;
        if (rt != ROLL_TICKS) begin tests_failed++; $display("FAIL retrig_ticks: got %0d expected %0d", rt, ROLL_TICKS); end
        if (dn != 1) begin tests_failed++; $display("FAIL retrig_done: got %0d pulses expected 1", dn); end
    endtask

    task automatic test_simultaneous();
        int c1 = -1, c2 = -1, n1 = 0, n2 = 0, r2 = 0;
        step(1'b0, 1'b1, 1'b1);
        tests_run++;
`ifdef ROLL_LOCK_EN
        if ({rolling1, rolling2} !== 2'b10) begin tests_failed++; $display("FAIL simul_start: got %0b expected 10", {rolling1, rolling2}); end
`else
        if ({rolling1, rolling2} !== 2'b11) begin tests_failed++; $display("FAIL simul_start: got %0b expected 11", {rolling1, rolling2}); end
`endif
        for (int i = 0; i < 2200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done1) begin n1++; c1 = i; end
            if (done2) begin n2++; c2 = i; end
            if (rolling2) r2++;
        end
        tests_run += 2;
        if (n1 != 1) begin tests_failed++; $display("FAIL simul_done1: got %0d pulses expected 1", n1); end
`ifdef ROLL_LOCK_EN
        if (n2 != 0 || r2 != 0) begin tests_failed++; $display("FAIL simul_lock2: got %0d done2 %0d rolling2 expected 0 0", n2, r2); end
`else
        if (n2 != 1 || c1 != c2) begin tests_failed++; $display("FAIL simul_done2: got %0d pulses at %0d expected 1 at %0d", n2, c2, c1); end
`endif
    endtask

    task automatic test_reset_mid_roll();
        int rt = 0, dn = 0;
        step(1'b0, 1'b1, 1'b0);
        while (rt < 500) begin
            if (rolling1) rt++;
            step(1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        #1;
        tests_run += 2;
        if (dice1 !== 4'd1) begin tests_failed++; $display("FAIL midrst_dice1: got %0d expected 1", dice1); end
        if (rolling1 !== 1'b0) begin tests_failed++; $display("FAIL midrst_rolling1: got %0b expected 0", rolling1); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done1) dn++;
        end
        tests_run++;
        if (dn != 0) begin tests_failed++; $display("FAIL midrst_done: got %0d pulses expected 0", dn); end
        rt = 0; dn = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000 && dn == 0; i++) begin
            if (rolling1) rt++;
            step(1'b1, 1'b0, 1'b0);
            if (done1) dn++;
        end
        tests_run += 2;
        if (rt != ROLL_TICKS) begin tests_failed++; $display("FAIL midrst_reroll_ticks: got %0d expected %0d", rt, ROLL_TICKS); end
        if (dn != 1) begin tests_failed++; $display("FAIL midrst_reroll_done: got %0d pulses expected 1", dn); end
        repeat (5) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_golden();
        int pops0;
        int guard = 0;
        pops0 = golden_pops;
        for (int i = 0; i < 50000; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0));
        end
        while ((!m_idle0 || !m_idle1) && guard < 3000) begin
            step(1'b1, 1'b0, 1'b0);
            guard++;
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        tests_run += 3;
        if (guard >= 3000) begin tests_failed++; $display("FAIL golden_drain: got %0d cycles expected < 3000", guard); end
        if (q0.size() + q1.size() != 0) begin tests_failed++; $display("FAIL golden_pending: got %0d unsettled expected 0", q0.size() + q1.size()); end
        if (golden_pops - pops0 < 10) begin tests_failed++; $display("FAIL golden_rolls: got %0d settles expected >= 10", golden_pops - pops0); end
    endtask

    initial begin
        test_reset();
        test_single_roll();
        test_retrigger();
        test_simultaneous();
        test_reset_mid_roll();
        test_golden();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
